// File: rtl/regfile_pipelined.sv
// Two-read/one-write register file with registered reads and a post-reset clear sweep.
// Optional same-edge write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_pipelined #(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWrite,
    input  logic [AW-1:0]   RD,
    input  logic [XLEN-1:0] WriteData,
    input  logic [AW-1:0]   RS1,
    input  logic [AW-1:0]   RS2,
    input  logic            clear_req,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    output logic            ready,
    output logic            fsm_state
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] mem [NREG];
    logic            wr_en;
    logic [XLEN-1:0] rd1_d, rd2_d;

    // Debug view of the FSM: 1 = READY, 0 = CLEAR.
    assign fsm_state = (state_q == READY);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            CLEAR: begin
                if (idx_q == AW'(NREG - 1)) begin
                    state_d = READY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            READY: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign wr_en = (state_q == READY) && RegWrite && !((ZERO_REG != 0) && (RD == '0));

    // Read path: the zero-register rule is applied after forwarding so it always wins.
    always_comb begin
        rd1_d = mem[RS1];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (RD == RS1)) rd1_d = WriteData;
`endif
        if ((ZERO_REG != 0) && (RS1 == '0)) rd1_d = '0;
        if (state_q != READY) rd1_d = '0;
    end

    always_comb begin
        rd2_d = mem[RS2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (RD == RS2)) rd2_d = WriteData;
`endif
        if ((ZERO_REG != 0) && (RS2 == '0)) rd2_d = '0;
        if (state_q != READY) rd2_d = '0;
    end

    // Storage has no reset; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[idx_q] <= '0;
        end else if (wr_en) begin
            mem[RD] <= WriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            idx_q     <= '0;
            ReadData1 <= '0;
            ReadData2 <= '0;
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ReadData1 <= rd1_d;
            ReadData2 <= rd2_d;
            ready     <= (state_d == READY);
        end
    end

endmodule

// File: tb/tb_regfile_pipelined.sv
// Self-checking bench for regfile_pipelined: one ZERO_REG=1 and one ZERO_REG=0 instance on shared inputs.
module tb_regfile_pipelined;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            RegWrite;
    logic [AW-1:0]   RD;
    logic [XLEN-1:0] WriteData;
    logic [AW-1:0]   RS1, RS2;
    logic            clear_req;
    logic [XLEN-1:0] rd1_z, rd2_z, rd1_n, rd2_n;
    logic            ready_z, ready_n, st_z, st_n;

    always #5 clk = ~clk;

    regfile_pipelined #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1)) u_dut_z (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
        .RS1(RS1), .RS2(RS2), .clear_req(clear_req), .ReadData1(rd1_z), .ReadData2(rd2_z),
        .ready(ready_z), .fsm_state(st_z)
    );

    regfile_pipelined #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(0)) u_dut_n (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
        .RS1(RS1), .RS2(RS2), .clear_req(clear_req), .ReadData1(rd1_n), .ReadData2(rd2_n),
        .ready(ready_n), .fsm_state(st_n)
    );

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] mem_z[NREG];
    logic [XLEN-1:0] mem_n[NREG];

    typedef struct {
        logic            we;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] wd;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [XLEN-1:0] e1;
        logic [XLEN-1:0] e2;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] mread(input bit z, input logic [AW-1:0] rs,
                                              input logic we, input logic [AW-1:0] rd,
                                              input logic [XLEN-1:0] wd);
        if (z && rs == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && rd == rs) return wd;
`endif
        return z ? mem_z[rs] : mem_n[rs];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NREG; i++) begin
            mem_z[i] = '0;
            mem_n[i] = '0;
        end
    endtask

    // One READY-state operation; e1/e2 are the expectations for the ZERO_REG=1 instance.
    task automatic drive_op(input string name, input logic we, input logic [AW-1:0] rd,
                            input logic [XLEN-1:0] wd, input logic [AW-1:0] rs1,
                            input logic [AW-1:0] rs2, input logic [XLEN-1:0] e1,
                            input logic [XLEN-1:0] e2);
        RegWrite  = we;
        RD        = rd;
        WriteData = wd;
        RS1       = rs1;
        RS2       = rs2;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(mread(1'b0, rs1, we, rd, wd));
        exp_q.push_back(mread(1'b0, rs2, we, rd, wd));
        @(posedge clk);
        if (we) begin
            mem_n[rd] = wd;
            if (rd != '0) mem_z[rd] = wd;
        end
        #1;
        RegWrite = 1'b0;
        check({name, "_rd1_z"}, rd1_z, exp_q.pop_front());
        check({name, "_rd2_z"}, rd2_z, exp_q.pop_front());
        check({name, "_rd1_n"}, rd1_n, exp_q.pop_front());
        check({name, "_rd2_n"}, rd2_n, exp_q.pop_front());
        check({name, "_ready"}, {63'd0, ready_z & ready_n}, 64'd1);
    endtask

    // Follows a sweep edge by edge; optionally pulses clear_req mid-sweep (must be ignored).
    task automatic wait_sweep(input string name, input int req_at);
        for (int e = 1; e <= NREG; e++) begin
            @(posedge clk);
            #1;
            check({name, "_ready_z"}, {63'd0, ready_z}, (e == NREG) ? 64'd1 : 64'd0);
            check({name, "_ready_n"}, {63'd0, ready_n}, (e == NREG) ? 64'd1 : 64'd0);
            check({name, "_out_z"}, rd1_z | rd2_z, 64'd0);
            check({name, "_out_n"}, rd1_n | rd2_n, 64'd0);
            clear_req = (e == req_at);
        end
        clear_req = 1'b0;
        clear_model();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rd1_z"}, rd1_z, 64'd0);
        check({name, "_rd2_z"}, rd2_z, 64'd0);
        check({name, "_rd1_n"}, rd1_n, 64'd0);
        check({name, "_rd2_n"}, rd2_n, 64'd0);
        check({name, "_ready"}, {63'd0, ready_z | ready_n}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [XLEN-1:0] c7, c31, rval, wdr;
        logic [AW-1:0]   rrd, rrs1, rrs2;
        logic            rwe;

`ifdef REGFILE_BYPASS_EN
        c7  = 64'h2;
        c31 = 64'hA5A5_A5A5_A5A5_A5A5;
`else
        c7  = 64'h1;
        c31 = 64'h0;
`endif
        vecs[0] = '{1'b1, 5'd5,  64'hDEADBEEF_CAFEF00D, 5'd0,  5'd1,  64'd0, 64'd0};
        vecs[1] = '{1'b0, 5'd0,  64'd0,                 5'd5,  5'd5,  64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
        vecs[2] = '{1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 5'd3, 64'hDEADBEEF_CAFEF00D, 64'd0};
        vecs[3] = '{1'b0, 5'd0,  64'd0,                 5'd0,  5'd0,  64'd0, 64'd0};
        vecs[4] = '{1'b1, 5'd7,  64'h1,                 5'd2,  5'd2,  64'd0, 64'd0};
        vecs[5] = '{1'b1, 5'd7,  64'h2,                 5'd7,  5'd5,  c7,    64'hDEADBEEF_CAFEF00D};
        vecs[6] = '{1'b0, 5'd0,  64'd0,                 5'd7,  5'd7,  64'h2, 64'h2};
        vecs[7] = '{1'b1, 5'd31, 64'hA5A5_A5A5_A5A5_A5A5, 5'd31, 5'd30, c31, 64'd0};
        vecs[8] = '{1'b1, 5'd0,  64'h1234,              5'd0,  5'd0,  64'd0, 64'd0};
        vecs[9] = '{1'b0, 5'd0,  64'd0,                 5'd31, 5'd0,  64'hA5A5_A5A5_A5A5_A5A5, 64'd0};

        reset = 1'b1; RegWrite = 1'b0; RD = '0; WriteData = '0;
        RS1 = '0; RS2 = '0; clear_req = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        RS1 = 5'd3; RS2 = 5'd9;
        wait_sweep("init_sweep", 0);

        for (int i = 0; i < 10; i++)
            drive_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].rd, vecs[i].wd,
                     vecs[i].rs1, vecs[i].rs2, vecs[i].e1, vecs[i].e2);

        for (int i = 0; i < 60; i++) begin
            rwe  = 1'($urandom_range(0, 1));
            rrd  = AW'($urandom_range(0, NREG - 1));
            rrs1 = ($urandom_range(0, 3) == 0) ? rrd : AW'($urandom_range(0, NREG - 1));
            rrs2 = AW'($urandom_range(0, NREG - 1));
            wdr  = {$urandom, $urandom};
            drive_op($sformatf("rand%0d", i), rwe, rrd, wdr, rrs1, rrs2,
                     mread(1'b1, rrs1, rwe, rrd, wdr), mread(1'b1, rrs2, rwe, rrd, wdr));
        end

        for (int i = 1; i < NREG; i++)
            drive_op($sformatf("fill%0d", i), 1'b1, AW'(i), XLEN'(i), AW'(i - 1), AW'(i),
                     mread(1'b1, AW'(i - 1), 1'b1, AW'(i), XLEN'(i)),
                     mread(1'b1, AW'(i), 1'b1, AW'(i), XLEN'(i)));

        // clear_req with a same-cycle write: the read is still live, ready drops at this edge.
        clear_req = 1'b1; RegWrite = 1'b1; RD = 5'd4; WriteData = 64'd99;
        RS1 = 5'd3; RS2 = 5'd4;
`ifdef REGFILE_BYPASS_EN
        rval = 64'd99;
`else
        rval = 64'd4;
`endif
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        check("clr_ready", {63'd0, ready_z | ready_n}, 64'd0);
        check("clr_rd1_z", rd1_z, 64'd3);
        check("clr_rd2_z", rd2_z, rval);
        check("clr_rd1_n", rd1_n, 64'd3);
        check("clr_rd2_n", rd2_n, rval);
        RegWrite = 1'b1; RD = 5'd6; WriteData = 64'd77;
        wait_sweep("clr_sweep", 10);
        RegWrite = 1'b0;
        for (int i = 0; i < NREG / 2; i++)
            drive_op($sformatf("cleared%0d", i), 1'b0, '0, '0, AW'(2 * i), AW'(2 * i + 1), 64'd0, 64'd0);

        drive_op("pre_rst_w", 1'b1, 5'd9, 64'h0BAD_F00D_1234_5678, 5'd1, 5'd2, 64'd0, 64'd0);
        drive_op("pre_rst_r", 1'b0, '0, '0, 5'd9, 5'd9, 64'h0BAD_F00D_1234_5678, 64'h0BAD_F00D_1234_5678);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_sweep("rst_sweep", 0);
        drive_op("after_rst", 1'b0, '0, '0, 5'd9, 5'd31, 64'd0, 64'd0);

        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_sweep_rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_sweep("mid_rst_sweep", 0);
        drive_op("final", 1'b0, '0, '0, 5'd0, 5'd31, 64'd0, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
